// File: rtl/alu_ac_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_ac_sequencer_if
// Description : Command stream bundle (valid/ready) feeding the accumulator
//               sequencer. The master drives commands and the slave returns
//               ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_ac_sequencer_if;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] in_cmd;
   logic [3:0] in_sel;
   logic [7:0] in_data;

   modport master (
      output in_valid,
      output in_cmd,
      output in_sel,
      output in_data,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_cmd,
      input  in_sel,
      input  in_data,
      output in_ready
   );
endinterface
`default_nettype wire

// File: rtl/alu_ac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_ac_sequencer
// Description : Accumulator controller for the 8-bit combinational ALU.
//               Accepts LOAD / EXEC / REPEAT / CLEAR commands, drives the ALU
//               from the AC, operand and select registers, writes the result
//               back into AC and keeps carry, zero and divide-by-zero status.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ac_sequencer #(
   parameter int REP_W = 4
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   alu_ac_sequencer_if.slave cmd,
   output logic [7:0]        alu_ac,
   output logic [7:0]        alu_sayi,
   output logic [3:0]        alu_secme,
   input  wire logic [7:0]   alu_out,
   input  wire logic         alu_carry,
   output logic [7:0]        ac_out,
   output logic              carry_flag,
   output logic              zero_flag,
   output logic              divz_flag,
   output logic              busy,
   output logic              done
);

   localparam logic [1:0] c_cmd_load   = 2'b00;
   localparam logic [1:0] c_cmd_exec   = 2'b01;
   localparam logic [1:0] c_cmd_repeat = 2'b10;
   localparam logic [1:0] c_cmd_clear  = 2'b11;

   localparam logic [3:0] c_sel_add = 4'b0000;
   localparam logic [3:0] c_sel_div = 4'b0011;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_EXEC = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       ac_q, ac_d;
   logic [7:0]       opnd_q, opnd_d;
   logic [3:0]       sel_q, sel_d;
   logic [REP_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             zero_q, zero_d;
   logic             divz_q, divz_d;
   logic             done_q, done_d;

   logic [REP_W-1:0] w_rep_n;
   logic             w_divz;

   assign w_rep_n = cmd.in_data[REP_W-1:0];
   // A divide with a zero operand must never be committed to AC.
   assign w_divz  = (sel_q == c_sel_div) && (opnd_q == 8'h00);

   // Next-state and register-update logic for both FSM states.
   always_comb begin
      state_d = state_q;
      ac_d    = ac_q;
      opnd_d  = opnd_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      zero_d  = zero_q;
      divz_d  = divz_q;
      done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cmd.in_valid) begin
               case (cmd.in_cmd)
                  c_cmd_load: begin
                     ac_d    = cmd.in_data;
                     carry_d = 1'b0;
                     zero_d  = (cmd.in_data == 8'h00);
                     done_d  = 1'b1;
                  end
                  c_cmd_exec: begin
                     sel_d   = cmd.in_sel;
                     opnd_d  = cmd.in_data;
                     cnt_d   = REP_W'(1);
                     state_d = ST_EXEC;
                  end
                  c_cmd_repeat: begin
                     // Select and operand stay as left by the last EXEC.
                     if (w_rep_n == '0) begin
                        done_d = 1'b1;
                     end else begin
                        cnt_d   = w_rep_n;
                        state_d = ST_EXEC;
                     end
                  end
                  c_cmd_clear: begin
                     ac_d    = 8'h00;
                     carry_d = 1'b0;
                     zero_d  = 1'b1;
                     divz_d  = 1'b0;
                     done_d  = 1'b1;
                  end
                  default: begin
                     done_d = 1'b0;
                  end
               endcase
            end
         end

         ST_EXEC: begin
            if (w_divz) begin
               // Abort the whole operation, leaving AC and other flags alone.
               divz_d  = 1'b1;
               cnt_d   = '0;
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               ac_d    = alu_out;
               zero_d  = (alu_out == 8'h00);
               carry_d = (sel_q == c_sel_add) ? alu_carry : 1'b0;
               cnt_d   = cnt_q - REP_W'(1);
               if (cnt_q <= REP_W'(1)) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ac_q    <= 8'h00;
         opnd_q  <= 8'h00;
         sel_q   <= 4'h0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b1;
         divz_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ac_q    <= ac_d;
         opnd_q  <= opnd_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         zero_q  <= zero_d;
         divz_q  <= divz_d;
         done_q  <= done_d;
      end
   end

   // Ready is held low while reset is asserted so nothing is taken in reset.
   assign cmd.in_ready = (state_q == ST_IDLE) && rst_n;

   assign alu_ac     = ac_q;
   assign alu_sayi   = opnd_q;
   assign alu_secme  = sel_q;
   assign ac_out     = ac_q;
   assign carry_flag = carry_q;
   assign zero_flag  = zero_q;
   assign divz_flag  = divz_q;
   assign busy       = (state_q == ST_EXEC);
   assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_ac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_ac_sequencer
// Description : Self-checking bench for alu_ac_sequencer with a behavioural
//               model of the 8-bit ALU (add, divide, rotate-left, AND).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_ac_sequencer;

   localparam logic [1:0] c_load   = 2'b00;
   localparam logic [1:0] c_exec   = 2'b01;
   localparam logic [1:0] c_repeat = 2'b10;
   localparam logic [1:0] c_clear  = 2'b11;

   typedef struct {
      logic [1:0] cmd;
      logic [3:0] sel;
      logic [7:0] data;
      logic [7:0] exp_ac;
      logic       exp_c;
      logic       exp_z;
      logic       exp_d;
      int         exp_busy;
   } vec_t;

   logic       clk;
   logic       rst_n;
   logic [7:0] alu_ac;
   logic [7:0] alu_sayi;
   logic [3:0] alu_secme;
   logic [7:0] alu_out;
   logic       alu_carry;
   logic [7:0] ac_out;
   logic       carry_flag;
   logic       zero_flag;
   logic       divz_flag;
   logic       busy;
   logic       done;

   int checks;
   int errors;
   int acc_cnt;

   alu_ac_sequencer_if cmd_if ();

   alu_ac_sequencer #(.REP_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd        (cmd_if),
      .alu_ac     (alu_ac),
      .alu_sayi   (alu_sayi),
      .alu_secme  (alu_secme),
      .alu_out    (alu_out),
      .alu_carry  (alu_carry),
      .ac_out     (ac_out),
      .carry_flag (carry_flag),
      .zero_flag  (zero_flag),
      .divz_flag  (divz_flag),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU; non-add ops deliberately return a carry value that the
   // controller is expected to ignore.
   always_comb begin
      alu_out   = alu_ac;
      alu_carry = 1'b0;
      case (alu_secme)
         4'b0000: {alu_carry, alu_out} = {1'b0, alu_ac} + {1'b0, alu_sayi};
         4'b0011: begin
            if (alu_sayi == 8'h00) begin
               alu_out   = 8'hFF;
               alu_carry = 1'b1;
            end else begin
               alu_out = alu_ac / alu_sayi;
            end
         end
         4'b0110: begin
            alu_out   = {alu_ac[6:0], alu_ac[7]};
            alu_carry = alu_ac[7];
         end
         4'b1000: alu_out = alu_ac & alu_sayi;
         default: alu_out = alu_ac;
      endcase
   end

   // Counts command handshakes actually taken by the DUT.
   always @(posedge clk) begin
      if (rst_n && cmd_if.in_valid && cmd_if.in_ready)
         acc_cnt <= acc_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one command, wait for acceptance, then follow it until done.
   task automatic send(input logic [1:0] c, input logic [3:0] s, input logic [7:0] d,
                       output int lat, output int busy_n, output int done_n);
      bit ok;
      ok     = 1'b0;
      lat    = 0;
      busy_n = 0;
      done_n = 0;
      @(negedge clk);
      cmd_if.in_valid = 1'b1;
      cmd_if.in_cmd   = c;
      cmd_if.in_sel   = s;
      cmd_if.in_data  = d;
      for (int k = 0; k < 20; k++) begin
         if (cmd_if.in_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (k == 0) cmd_if.in_valid = 1'b0;
         lat++;
         if (busy) busy_n++;
         if (done) begin
            done_n++;
            break;
         end
      end
   endtask

   vec_t vecs [16];

   initial begin
      int lat, bn, dn, waited, acc_base, dcount, bcount;
      bit seen;

      vecs[0]  = '{c_load,   4'h0, 8'h05, 8'h05, 1'b0, 1'b0, 1'b0, 0};
      vecs[1]  = '{c_exec,   4'h0, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0, 1};
      vecs[2]  = '{c_load,   4'h0, 8'hC8, 8'hC8, 1'b0, 1'b0, 1'b0, 0};
      vecs[3]  = '{c_exec,   4'h0, 8'h64, 8'h2C, 1'b1, 1'b0, 1'b0, 1};
      vecs[4]  = '{c_exec,   4'h8, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1};
      vecs[5]  = '{c_load,   4'h0, 8'h81, 8'h81, 1'b0, 1'b0, 1'b0, 0};
      vecs[6]  = '{c_exec,   4'h6, 8'h00, 8'h03, 1'b0, 1'b0, 1'b0, 1};
      vecs[7]  = '{c_repeat, 4'hF, 8'h04, 8'h30, 1'b0, 1'b0, 1'b0, 4};
      vecs[8]  = '{c_load,   4'h0, 8'h09, 8'h09, 1'b0, 1'b0, 1'b0, 0};
      vecs[9]  = '{c_exec,   4'h3, 8'h00, 8'h09, 1'b0, 1'b0, 1'b1, 1};
      vecs[10] = '{c_exec,   4'h0, 8'h01, 8'h0A, 1'b0, 1'b0, 1'b1, 1};
      vecs[11] = '{c_clear,  4'h0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 0};
      vecs[12] = '{c_repeat, 4'h0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 0};
      vecs[13] = '{c_load,   4'h0, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 0};
      vecs[14] = '{c_exec,   4'h0, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1};
      vecs[15] = '{c_repeat, 4'h0, 8'h02, 8'h02, 1'b0, 1'b0, 1'b0, 2};

      checks  = 0;
      errors  = 0;
      acc_cnt = 0;

      // Reset with a command offered: it must not be taken.
      rst_n           = 1'b0;
      cmd_if.in_valid = 1'b1;
      cmd_if.in_cmd   = c_load;
      cmd_if.in_sel   = 4'h0;
      cmd_if.in_data  = 8'hAA;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", cmd_if.in_ready, 1'b0);
      chk("rst_ac",       ac_out,    8'h00);
      chk("rst_flags",    {carry_flag, zero_flag, divz_flag}, 3'b010);
      chk("rst_busy_done", {busy, done}, 2'b00);
      chk("rst_alu_ports", {alu_ac, alu_sayi, alu_secme}, 20'h0);
      cmd_if.in_valid = 1'b0;
      rst_n           = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", cmd_if.in_ready, 1'b1);
      chk("post_rst_ac",    ac_out, 8'h00);

      for (int i = 0; i < 16; i++) begin
         send(vecs[i].cmd, vecs[i].sel, vecs[i].data, lat, bn, dn);
         chk($sformatf("v%0d_done", i),    dn, 1);
         chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_busy + 1);
         chk($sformatf("v%0d_busy", i),    bn, vecs[i].exp_busy);
         chk($sformatf("v%0d_ac", i),      ac_out, vecs[i].exp_ac);
         chk($sformatf("v%0d_alu_ac", i),  alu_ac, vecs[i].exp_ac);
         chk($sformatf("v%0d_flags", i),   {carry_flag, zero_flag, divz_flag},
             {vecs[i].exp_c, vecs[i].exp_z, vecs[i].exp_d});
         @(negedge clk);
         chk($sformatf("v%0d_done_single", i), done, 1'b0);
      end

      // Command held valid during a REPEAT of 3 is taken exactly once.
      send(c_load, 4'h0, 8'h10, lat, bn, dn);
      send(c_exec, 4'h0, 8'h01, lat, bn, dn);
      chk("hold_setup_ac", ac_out, 8'h11);
      chk("hold_alu_sel_opnd", {alu_secme, alu_sayi}, 12'h001);
      @(negedge clk);
      cmd_if.in_valid = 1'b1;
      cmd_if.in_cmd   = c_repeat;
      cmd_if.in_data  = 8'h03;
      chk("hold_rep_ready", cmd_if.in_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      cmd_if.in_cmd  = c_load;
      cmd_if.in_data = 8'h55;
      acc_base = acc_cnt;
      waited   = 0;
      seen     = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (cmd_if.in_ready) begin
            seen = 1'b1;
            break;
         end
         waited++;
         @(negedge clk);
      end
      chk("hold_ready_seen", seen, 1'b1);
      chk("hold_wait_cycles", waited, 3);
      chk("hold_rep_done", done, 1'b1);
      chk("hold_rep_ac", ac_out, 8'h14);
      chk("hold_no_accept_yet", acc_cnt - acc_base, 0);
      @(posedge clk);
      @(negedge clk);
      cmd_if.in_valid = 1'b0;
      chk("hold_load_ac", ac_out, 8'h55);
      chk("hold_load_done", done, 1'b1);
      repeat (3) @(negedge clk);
      chk("hold_accept_once", acc_cnt - acc_base, 1);
      chk("hold_ac_stable", ac_out, 8'h55);

      // Reset during the 5th busy cycle of a REPEAT 15 of add 1 from zero.
      send(c_load, 4'h0, 8'h00, lat, bn, dn);
      @(negedge clk);
      cmd_if.in_valid = 1'b1;
      cmd_if.in_cmd   = c_repeat;
      cmd_if.in_data  = 8'h0F;
      @(posedge clk);
      bcount = 0;
      for (int b = 1; b <= 5; b++) begin
         @(negedge clk);
         if (b == 1) cmd_if.in_valid = 1'b0;
         if (busy) bcount++;
      end
      chk("rstmid_busy_cycles", bcount, 5);
      chk("rstmid_ac_before", ac_out, 8'h04);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rstmid_ac", ac_out, 8'h00);
      chk("rstmid_busy_done", {busy, done}, 2'b00);
      chk("rstmid_ready_low", cmd_if.in_ready, 1'b0);
      chk("rstmid_flags", {carry_flag, zero_flag, divz_flag}, 3'b010);
      rst_n  = 1'b1;
      dcount = 0;
      bcount = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (done) dcount++;
         if (busy) bcount++;
      end
      chk("rstmid_no_done", dcount, 0);
      chk("rstmid_no_busy", bcount, 0);
      chk("rstmid_ready_high", cmd_if.in_ready, 1'b1);
      chk("rstmid_ac_after", ac_out, 8'h00);
      send(c_load, 4'h0, 8'h3C, lat, bn, dn);
      chk("rstmid_resume_load", {ac_out, lat[7:0]}, {8'h3C, 8'd1});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
